// File: rtl/axi4_rd_arbiter_if.sv
// AR/R bundle between N upstream masters, the arbiter and one downstream slave.
// master modport is the arbiter's view; slave modport is the environment driving masters and the slave.
interface axi4_rd_arbiter_if #(
   parameter int N_MST  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int USER_W = 1
) ();
   localparam int IX_W   = $clog2(N_MST);
   localparam int M_ID_W = ID_W + IX_W;
   localparam int SB_W   = 16 + USER_W;

   logic [N_MST-1:0]        s_arvalid;
   logic [N_MST-1:0]        s_arready;
   logic [N_MST*ID_W-1:0]   s_arid;
   logic [N_MST*ADDR_W-1:0] s_araddr;
   logic [N_MST*8-1:0]      s_arlen;
   logic [N_MST*3-1:0]      s_arsize;
   logic [N_MST*2-1:0]      s_arburst;
   logic [N_MST*SB_W-1:0]   s_arsb;
   logic [N_MST-1:0]        s_rvalid;
   logic [N_MST-1:0]        s_rready;
   logic [ID_W-1:0]         s_rid;
   logic [DATA_W-1:0]       s_rdata;
   logic [1:0]              s_rresp;
   logic                    s_rlast;
   logic [USER_W-1:0]       s_ruser;

   logic                    m_arvalid;
   logic                    m_arready;
   logic [M_ID_W-1:0]       m_arid;
   logic [ADDR_W-1:0]       m_araddr;
   logic [7:0]              m_arlen;
   logic [2:0]              m_arsize;
   logic [1:0]              m_arburst;
   logic [SB_W-1:0]         m_arsb;
   logic                    m_rvalid;
   logic                    m_rready;
   logic [M_ID_W-1:0]       m_rid;
   logic [DATA_W-1:0]       m_rdata;
   logic [1:0]              m_rresp;
   logic                    m_rlast;
   logic [USER_W-1:0]       m_ruser;

   modport master (
      input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arsb, s_rready,
             m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, m_ruser,
      output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, s_ruser,
             m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arsb, m_rready
   );

   modport slave (
      output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arsb, s_rready,
             m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, m_ruser,
      input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, s_ruser,
             m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arsb, m_rready
   );
endinterface

// File: rtl/axi4_rd_arbiter.sv
// N:1 AXI4 read arbiter: round-robin AR grant, registered AR (m_arvalid 1 cycle after grant, <=1 AR per 2 cycles),
// held until m_arready; R routed combinationally by ID prefix with per-master outstanding-burst limits.
module axi4_rd_arbiter #(
   parameter int N_MST    = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 64,
   parameter int ID_W     = 4,
   parameter int USER_W   = 1,
   parameter int MAX_OUTS = 8
) (
   input  logic              aclk,
   input  logic              areset_n,
   axi4_rd_arbiter_if.master bus,
   output logic              err_rid
);
   localparam int IX_W   = $clog2(N_MST);
   localparam int M_ID_W = ID_W + IX_W;
   localparam int SB_W   = 16 + USER_W;
   localparam int CNT_W  = $clog2(MAX_OUTS + 1);
   localparam logic [IX_W:0]    NUM_MST  = (IX_W+1)'(N_MST);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTS);
   localparam logic [IX_W-1:0]  LAST_MST = IX_W'(N_MST - 1);

   typedef enum logic {IDLE, HOLD} state_t;
   state_t r_state, w_state_nxt;

   logic [IX_W-1:0]   r_rr_ptr, r_gnt, w_gnt, w_ptr_nxt, w_ix;
   logic [IX_W:0]     w_idx;
   logic              w_gnt_vld, w_capture, w_ar_done;
   logic              w_mapped, w_last_hs, w_cnt_zero, w_err_set;
   logic [N_MST-1:0]  w_elig, w_inc, w_dec;
   logic [CNT_W-1:0]  r_outs [N_MST];
   logic [M_ID_W-1:0] r_arid;
   logic [ADDR_W-1:0] r_araddr;
   logic [7:0]        r_arlen;
   logic [2:0]        r_arsize;
   logic [1:0]        r_arburst;
   logic [SB_W-1:0]   r_arsb;

   // First eligible master at or after the round-robin pointer, wrapping.
   always_comb begin
      w_elig    = '0;
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_idx     = '0;
      for (int i = 0; i < N_MST; i++)
         w_elig[i] = bus.s_arvalid[i] && (r_outs[i] < MAX_CNT);
      for (int k = 0; k < N_MST; k++) begin
         w_idx = {1'b0, r_rr_ptr} + (IX_W+1)'(k);
         if (w_idx >= NUM_MST)
            w_idx = w_idx - NUM_MST;
         if (!w_gnt_vld && w_elig[w_idx[IX_W-1:0]]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_idx[IX_W-1:0];
         end
      end
   end

   assign w_capture = (r_state == IDLE) && w_gnt_vld && areset_n;
   assign w_ptr_nxt = (r_gnt == LAST_MST) ? '0 : r_gnt + 1'b1;

   always_comb begin
      w_state_nxt   = r_state;
      bus.s_arready = '0;
      bus.m_arvalid = 1'b0;
      w_ar_done     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_capture) begin
               bus.s_arready[w_gnt] = 1'b1;
               w_state_nxt          = HOLD;
            end
         end
         HOLD: begin
            bus.m_arvalid = 1'b1;
            if (bus.m_arready) begin
               w_ar_done   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Unmapped prefixes are sunk so a bad slave ID can never wedge the R channel.
   always_comb begin
      w_ix          = bus.m_rid[M_ID_W-1:ID_W];
      w_mapped      = ({1'b0, w_ix} < NUM_MST);
      bus.s_rvalid  = '0;
      bus.m_rready  = 1'b1;
      if (w_mapped) begin
         bus.s_rvalid[w_ix] = bus.m_rvalid;
         bus.m_rready       = bus.s_rready[w_ix];
      end
   end

   assign bus.s_rid   = bus.m_rid[ID_W-1:0];
   assign bus.s_rdata = bus.m_rdata;
   assign bus.s_rresp = bus.m_rresp;
   assign bus.s_rlast = bus.m_rlast;
   assign bus.s_ruser = bus.m_ruser;

   always_comb begin
      w_last_hs  = bus.m_rvalid && bus.m_rready && bus.m_rlast && w_mapped;
      w_cnt_zero = 1'b0;
      w_inc      = '0;
      w_dec      = '0;
      for (int i = 0; i < N_MST; i++) begin
         w_inc[i] = w_capture && (w_gnt == IX_W'(i));
         if (w_last_hs && (w_ix == IX_W'(i))) begin
            if (r_outs[i] == '0)
               w_cnt_zero = 1'b1;
            else
               w_dec[i] = 1'b1;
         end
      end
      w_err_set = (bus.m_rvalid && !w_mapped) || w_cnt_zero;
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         r_state   <= IDLE;
         r_rr_ptr  <= '0;
         r_gnt     <= '0;
         r_arid    <= '0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arburst <= '0;
         r_arsb    <= '0;
         err_rid   <= 1'b0;
         for (int i = 0; i < N_MST; i++)
            r_outs[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_gnt     <= w_gnt;
            r_arid    <= {w_gnt, bus.s_arid[w_gnt*ID_W +: ID_W]};
            r_araddr  <= bus.s_araddr[w_gnt*ADDR_W +: ADDR_W];
            r_arlen   <= bus.s_arlen[w_gnt*8 +: 8];
            r_arsize  <= bus.s_arsize[w_gnt*3 +: 3];
            r_arburst <= bus.s_arburst[w_gnt*2 +: 2];
            r_arsb    <= bus.s_arsb[w_gnt*SB_W +: SB_W];
         end
         if (w_ar_done)
            r_rr_ptr <= w_ptr_nxt;
         for (int i = 0; i < N_MST; i++) begin
            if (w_inc[i] && !w_dec[i])
               r_outs[i] <= r_outs[i] + 1'b1;
            else if (w_dec[i] && !w_inc[i])
               r_outs[i] <= r_outs[i] - 1'b1;
         end
         if (w_err_set)
            err_rid <= 1'b1;
      end
   end

   assign bus.m_arid    = r_arid;
   assign bus.m_araddr  = r_araddr;
   assign bus.m_arlen   = r_arlen;
   assign bus.m_arsize  = r_arsize;
   assign bus.m_arburst = r_arburst;
   assign bus.m_arsb    = r_arsb;
endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench: two-master instance for arbitration/limits/routing, three-master instance for unmapped prefixes.
module tb_axi4_rd_arbiter;
   logic aclk = 1'b0;
   logic areset_n;
   logic err_rid, err_rid3;
   int   tests = 0;
   int   fails = 0;

   always #5 aclk = ~aclk;

   axi4_rd_arbiter_if #(.N_MST(2), .ADDR_W(32), .DATA_W(64), .ID_W(4), .USER_W(1)) bif ();
   axi4_rd_arbiter_if #(.N_MST(3), .ADDR_W(32), .DATA_W(64), .ID_W(4), .USER_W(1)) bif3 ();

   axi4_rd_arbiter #(.N_MST(2), .ADDR_W(32), .DATA_W(64), .ID_W(4), .USER_W(1), .MAX_OUTS(8)) u_dut (
      .aclk(aclk), .areset_n(areset_n), .bus(bif.master), .err_rid(err_rid));

   axi4_rd_arbiter #(.N_MST(3), .ADDR_W(32), .DATA_W(64), .ID_W(4), .USER_W(1), .MAX_OUTS(8)) u_dut3 (
      .aclk(aclk), .areset_n(areset_n), .bus(bif3.master), .err_rid(err_rid3));

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic init_inputs();
      bif.s_arvalid = '0; bif.s_arid = '0; bif.s_araddr = '0; bif.s_arlen = '0;
      bif.s_arsize = '0; bif.s_arburst = '0; bif.s_arsb = '0; bif.s_rready = '0;
      bif.m_arready = 1'b0; bif.m_rvalid = 1'b0; bif.m_rid = '0; bif.m_rdata = '0;
      bif.m_rresp = '0; bif.m_rlast = 1'b0; bif.m_ruser = '0;
      bif3.s_arvalid = '0; bif3.s_arid = '0; bif3.s_araddr = '0; bif3.s_arlen = '0;
      bif3.s_arsize = '0; bif3.s_arburst = '0; bif3.s_arsb = '0; bif3.s_rready = '0;
      bif3.m_arready = 1'b0; bif3.m_rvalid = 1'b0; bif3.m_rid = '0; bif3.m_rdata = '0;
      bif3.m_rresp = '0; bif3.m_rlast = 1'b0; bif3.m_ruser = '0;
   endtask

   task automatic test_reset();
      areset_n = 1'b0;
      bif.s_arvalid = 2'b11;
      step();
      step();
      tests++; if (bif.m_arvalid !== 1'b0) begin fails++; $display("FAIL rst_arvalid got=%0h exp=0", bif.m_arvalid); end
      tests++; if (bif.s_arready !== 2'b00) begin fails++; $display("FAIL rst_arready got=%0h exp=0", bif.s_arready); end
      tests++; if (err_rid !== 1'b0) begin fails++; $display("FAIL rst_err got=%0h exp=0", err_rid); end
      tests++; if (bif.s_rvalid !== 2'b00) begin fails++; $display("FAIL rst_rvalid got=%0h exp=0", bif.s_rvalid); end
      bif.s_arvalid = 2'b00;
      areset_n = 1'b1;
      step();
   endtask

   task automatic test_single_ar();
      bif.m_arready = 1'b0;
      bif.s_arvalid = 2'b01;
      bif.s_arid[3:0] = 4'h3;
      bif.s_araddr[31:0] = 32'h1000;
      bif.s_arlen[7:0] = 8'd3;
      bif.s_arsize[2:0] = 3'd3;
      bif.s_arburst[1:0] = 2'd1;
      bif.s_arsb[16:0] = 17'h12345;
      #1;
      tests++; if (bif.s_arready !== 2'b01) begin fails++; $display("FAIL t1_arready got=%0h exp=1", bif.s_arready); end
      tests++; if (bif.m_arvalid !== 1'b0) begin fails++; $display("FAIL t1_arvalid_pre got=%0h exp=0", bif.m_arvalid); end
      step();
      bif.s_arvalid = 2'b00;
      #1;
      tests++; if (bif.m_arvalid !== 1'b1) begin fails++; $display("FAIL t1_arvalid got=%0h exp=1", bif.m_arvalid); end
      tests++; if (bif.m_arid !== 5'h03) begin fails++; $display("FAIL t1_arid got=%0h exp=03", bif.m_arid); end
      tests++; if (bif.m_araddr !== 32'h1000) begin fails++; $display("FAIL t1_araddr got=%0h exp=1000", bif.m_araddr); end
      tests++; if (bif.m_arlen !== 8'd3 || bif.m_arsize !== 3'd3 || bif.m_arburst !== 2'd1)
         begin fails++; $display("FAIL t1_lensizeburst got=%0h/%0h/%0h exp=3/3/1", bif.m_arlen, bif.m_arsize, bif.m_arburst); end
      tests++; if (bif.m_arsb !== 17'h12345) begin fails++; $display("FAIL t1_arsb got=%0h exp=12345", bif.m_arsb); end
      bif.m_arready = 1'b1;
      step();
      bif.m_arready = 1'b0;
      #1;
      tests++; if (bif.m_arvalid !== 1'b0) begin fails++; $display("FAIL t1_arvalid_done got=%0h exp=0", bif.m_arvalid); end
   endtask

   task automatic test_hold_stable();
      bif.s_arvalid = 2'b11;
      bif.s_arid = 8'hA1;
      bif.s_araddr = 64'h2000_0040_0000_0030;
      bif.s_arlen = 16'h0702;
      #1;
      tests++; if (bif.s_arready !== 2'b10) begin fails++; $display("FAIL t3_grant got=%0h exp=2", bif.s_arready); end
      step();
      for (int k = 0; k < 5; k++) begin
         bif.s_araddr = {32'hDEAD_0000 + k, 32'hBEEF_0000 + k};
         bif.s_arid = 8'h55 + 8'(k);
         #1;
         tests++; if (bif.m_arvalid !== 1'b1 || bif.m_arid !== 5'h1A || bif.m_araddr !== 32'h2000_0040 || bif.m_arlen !== 8'd7)
            begin fails++; $display("FAIL t3_hold_%0d got=%0h/%0h/%0h/%0h exp=1/1a/20000040/7", k, bif.m_arvalid, bif.m_arid, bif.m_araddr, bif.m_arlen); end
         tests++; if (bif.s_arready !== 2'b00) begin fails++; $display("FAIL t3_noready_%0d got=%0h exp=0", k, bif.s_arready); end
         step();
      end
      bif.m_arready = 1'b1;
      step();
      bif.s_arvalid = 2'b00;
   endtask

   task automatic test_back_to_back();
      int gnt;
      bif.m_arready = 1'b1;
      bif.s_arvalid = 2'b11;
      bif.s_arid = 8'h69;
      for (int k = 0; k < 8; k++) begin
         gnt = (k / 2) % 2;
         #1;
         if (k % 2 == 0) begin
            tests++; if (bif.s_arready !== 2'(1 << gnt) || bif.m_arvalid !== 1'b0)
               begin fails++; $display("FAIL t2_grant_%0d got=%0h/%0h exp=%0h/0", k, bif.s_arready, bif.m_arvalid, 1 << gnt); end
         end else begin
            tests++; if (bif.m_arvalid !== 1'b1 || bif.m_arid !== (gnt == 1 ? 5'h16 : 5'h09) || bif.s_arready !== 2'b00)
               begin fails++; $display("FAIL t2_ar_%0d got=%0h/%0h exp=1/%0h", k, bif.m_arvalid, bif.m_arid, gnt == 1 ? 5'h16 : 5'h09); end
         end
         step();
      end
      bif.s_arvalid = 2'b00;
   endtask

   task automatic test_outs_limit();
      test_reset();
      bif.m_arready = 1'b1;
      bif.s_arvalid = 2'b10;
      bif.s_arid = 8'hC2;
      bif.s_araddr = 64'h0000_4000_0000_5000;
      for (int k = 0; k < 8; k++) begin
         #1;
         tests++; if (bif.s_arready !== 2'b10) begin fails++; $display("FAIL t4_m1_grant_%0d got=%0h exp=2", k, bif.s_arready); end
         step();
         tests++; if (bif.m_arvalid !== 1'b1 || bif.m_arid !== 5'h1C)
            begin fails++; $display("FAIL t4_m1_ar_%0d got=%0h/%0h exp=1/1c", k, bif.m_arvalid, bif.m_arid); end
         step();
      end
      #1;
      tests++; if (bif.s_arready !== 2'b00) begin fails++; $display("FAIL t4_ninth_blocked got=%0h exp=0", bif.s_arready); end
      step();
      tests++; if (bif.s_arready !== 2'b00 || bif.m_arvalid !== 1'b0)
         begin fails++; $display("FAIL t4_still_blocked got=%0h/%0h exp=0/0", bif.s_arready, bif.m_arvalid); end
      bif.s_arvalid = 2'b11;
      #1;
      tests++; if (bif.s_arready !== 2'b01) begin fails++; $display("FAIL t4_m0_grant got=%0h exp=1", bif.s_arready); end
      step();
      step();
      tests++; if (bif.s_arready !== 2'b01) begin fails++; $display("FAIL t4_m1_skipped got=%0h exp=1", bif.s_arready); end
      step();
      step();
      bif.s_arvalid = 2'b10;
   endtask

   task automatic test_r_backpressure();
      bif.m_rvalid = 1'b1;
      bif.m_rid = 5'h15;
      bif.m_rlast = 1'b1;
      bif.m_rdata = 64'h0123_4567_89AB_CDEF;
      bif.m_rresp = 2'b01;
      bif.s_rready = 2'b00;
      for (int k = 0; k < 2; k++) begin
         #1;
         tests++; if (bif.s_rvalid !== 2'b10 || bif.s_rid !== 4'h5 || bif.m_rready !== 1'b0)
            begin fails++; $display("FAIL t5_stall_%0d got=%0h/%0h/%0h exp=2/5/0", k, bif.s_rvalid, bif.s_rid, bif.m_rready); end
         tests++; if (bif.s_rdata !== 64'h0123_4567_89AB_CDEF || bif.s_rresp !== 2'b01 || bif.s_rlast !== 1'b1)
            begin fails++; $display("FAIL t5_payload_%0d got=%0h/%0h/%0h", k, bif.s_rdata, bif.s_rresp, bif.s_rlast); end
         tests++; if (bif.s_arready !== 2'b00) begin fails++; $display("FAIL t5_no_grant_%0d got=%0h exp=0", k, bif.s_arready); end
         step();
      end
      bif.s_rready = 2'b10;
      #1;
      tests++; if (bif.m_rready !== 1'b1) begin fails++; $display("FAIL t5_rready got=%0h exp=1", bif.m_rready); end
      step();
      bif.m_rvalid = 1'b0;
      bif.s_rready = 2'b00;
      #1;
      tests++; if (bif.s_arready !== 2'b10) begin fails++; $display("FAIL t5_ninth_grant got=%0h exp=2", bif.s_arready); end
      step();
      tests++; if (bif.m_arvalid !== 1'b1 || bif.m_arid !== 5'h1C)
         begin fails++; $display("FAIL t5_ninth_ar got=%0h/%0h exp=1/1c", bif.m_arvalid, bif.m_arid); end
      bif.s_arvalid = 2'b00;
      step();
      tests++; if (err_rid !== 1'b0) begin fails++; $display("FAIL t5_err_clean got=%0h exp=0", err_rid); end
   endtask

   task automatic test_err_rid();
      test_reset();
      bif.m_rvalid = 1'b1;
      bif.m_rid = 5'h03;
      bif.m_rlast = 1'b0;
      bif.s_rready = 2'b01;
      #1;
      tests++; if (bif.m_rready !== 1'b1 || bif.s_rvalid !== 2'b01)
         begin fails++; $display("FAIL t6_route0 got=%0h/%0h exp=1/1", bif.m_rready, bif.s_rvalid); end
      step();
      tests++; if (err_rid !== 1'b0) begin fails++; $display("FAIL t6_nonlast_noerr got=%0h exp=0", err_rid); end
      bif.m_rlast = 1'b1;
      step();
      bif.m_rvalid = 1'b0;
      bif.s_rready = 2'b00;
      #1;
      tests++; if (err_rid !== 1'b1) begin fails++; $display("FAIL t6_zero_outs_err got=%0h exp=1", err_rid); end
      bif3.m_rvalid = 1'b1;
      bif3.m_rid = 6'h35;
      bif3.s_rready = 3'b000;
      #1;
      tests++; if (bif3.m_rready !== 1'b1 || bif3.s_rvalid !== 3'b000 || err_rid3 !== 1'b0)
         begin fails++; $display("FAIL t6_unmapped_sink got=%0h/%0h/%0h exp=1/0/0", bif3.m_rready, bif3.s_rvalid, err_rid3); end
      step();
      bif3.m_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         tests++; if (err_rid !== 1'b1 || err_rid3 !== 1'b1)
            begin fails++; $display("FAIL t6_sticky_%0d got=%0h/%0h exp=1/1", k, err_rid, err_rid3); end
         step();
      end
      bif.s_arvalid = 2'b01;
      bif.m_arready = 1'b0;
      step();
      tests++; if (bif.m_arvalid !== 1'b1) begin fails++; $display("FAIL t6_hold got=%0h exp=1", bif.m_arvalid); end
      areset_n = 1'b0;
      step();
      tests++; if (bif.m_arvalid !== 1'b0 || err_rid !== 1'b0 || err_rid3 !== 1'b0 || bif.s_arready !== 2'b00)
         begin fails++; $display("FAIL t6_reset_mid_hold got=%0h/%0h/%0h/%0h exp=0/0/0/0", bif.m_arvalid, err_rid, err_rid3, bif.s_arready); end
      areset_n = 1'b1;
      bif.s_arvalid = 2'b00;
      step();
   endtask

   initial begin
      areset_n = 1'b0;
      init_inputs();
      test_reset();
      test_single_ar();
      test_hold_stable();
      test_back_to_back();
      test_outs_limit();
      test_r_backpressure();
      test_err_rid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
